fpu_result_arb: RTL and testbench
=================================

Name: fpu_result_arb

Overview:
- Downstream collector for the FPU sub-units: fpmv, fcmp, fma, fcvt and similar, each with its own valid/ready and a 2-stage pipeline.
- Arbitrates their completed results round-robin into one registered output slot that feeds the FPU writeback path.
- Keeps a sticky accumulator of exception flags for the FCSR.

Parameters:
- EXPWIDTH, 8, exponent width of the result word.
- PRECISION, 24, significand width incl. hidden bit; result word width W = EXPWIDTH+PRECISION.
- NUM_SRC, 4, number of sub-unit sources, 2..8.
- SRC_W, $clog2(NUM_SRC), width of the source index.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- src_valid_i  in  NUM_SRC  per-source result valid.
- src_ready_o  out  NUM_SRC  per-source accept; a source transfers when valid&ready.
- src_result_i  in  NUM_SRC*W  packed results; source k occupies bits [k*W +: W].
- src_fflags_i  in  NUM_SRC*5  packed fflags {NV,DZ,OF,UF,NX}; source k occupies bits [k*5 +: 5].
- out_valid_o  out  1  output slot holds a result.
- out_ready_i  in  1  writeback accepts the output.
- out_result_o  out  W  registered result.
- out_fflags_o  out  5  registered fflags of that result.
- out_src_o  out  SRC_W  index of the source that produced the output.
- fflags_clr_i  in  1  clear the sticky accumulator (FCSR write).
- fflags_acc_o  out  5  sticky OR of the fflags of all results delivered to writeback.

Behaviour:
- Reset: out_valid_o=0, out_result_o=0, out_fflags_o=0, out_src_o=0, fflags_acc_o=0, round-robin pointer rr=0. src_ready_o follows combinationally: all 0 at reset, since no source is valid.
- Slot free condition: slot_free = !out_valid_o || out_ready_i.
- Arbitration (combinational): grant is the first valid source at or after rr, searching modulo NUM_SRC.
- src_ready_o[k] = slot_free && grant==k. At most one ready bit is high.
- src_ready_o must not depend on src_valid_i of other sources beyond the grant logic. It must never depend on out_result/flags.
- Accept (any valid & ready), on the next edge:
  - out_result_o and out_fflags_o load the granted source's data.
  - out_src_o = grant; out_valid_o = 1.
  - rr = (grant+1) mod NUM_SRC.
- Latency: exactly 1 cycle from source accept to out_valid_o.
- Throughput: 1 result/cycle while out_ready_i=1 (back-to-back, no bubble).
- Output drained with no new accept (out_valid_o && out_ready_i and no source valid): out_valid_o -> 0. Data registers hold their old values.
- Stall (out_valid_o && !out_ready_i): all src_ready_o=0; out_* and rr hold stable.
- No valid source: rr holds.
- Accumulator, evaluated at each edge:
  - A delivery is out_valid_o && out_ready_i.
  - fflags_clr_i=1 and a delivery: acc = out_fflags_o. Clear wins over the old value; the delivered flags are still recorded.
  - fflags_clr_i=1, no delivery: acc = 0.
  - Otherwise acc |= (delivery ? out_fflags_o : 0).
- rr wrap: grant NUM_SRC-1 -> rr=0.
- Non-power-of-2 NUM_SRC: indices >= NUM_SRC are never granted.
- Reset asserted mid-stream: in-flight output is dropped and everything returns to reset values immediately (asynchronous).

Decomposition:
- Shared FPU package (define.v style) holds the FFLAGS index constants (NV=4, DZ=3, OF=2, UF=1, NX=0) and the default source-index assignment (FPU_SRC_FMA=0, CMP=1, MV=2, CVT=3).
- One natural sub-module: rr_arbiter. Inputs: req vector and ptr. Outputs: one-hot grant and index. It is purely combinational and reusable by the SFU/LSU writeback.

Test Plan:
- Single source: src2 valid with result 0x3F800000, flags 0, out_ready=1 -> src_ready_o=4'b0100; next cycle out_valid=1, out_result=0x3F800000, out_src=2; rr=3.
- All 4 sources valid continuously, out_ready=1 -> out_src sequence 0,1,2,3,0 on consecutive cycles, no bubbles.
- Backpressure: output occupied, out_ready=0 for 3 cycles with src1 and src3 valid -> src_ready_o=0 and out_* stable. out_ready=1 -> delivery that cycle, and the granted source is accepted the same cycle (rr order).
- Flags: deliver results with flags 5'b00001 then 5'b10000 -> fflags_acc_o=5'b10001. Then fflags_clr_i=1 during delivery of 5'b00100 -> acc=5'b00100.
- Clear without delivery: acc=5'b10001, fflags_clr_i=1, no out_valid -> acc=0 next cycle.
- Async reset while out_valid=1 and rr=2 -> out_valid_o=0, rr=0, acc=0 immediately. After release, src0 has priority on the first request.

Source files
------------

// File: rtl/fpu_result_arb_pkg.sv
// Shared FPU definitions for the result collector and its arbiter.
//   fflag_idx_e : bit positions inside a 5-bit fflags word {NV,DZ,OF,UF,NX}
//   fpu_src_e   : default source-index assignment of the FPU sub-units
//   fflags_t    : 5-bit exception flag word
//   fflags_acc_next : next value of the sticky FCSR flag accumulator
package fpu_result_arb_pkg;

  localparam int FFLAGS_W = 5;

  typedef enum int {
    FFLAG_NX = 0,
    FFLAG_UF = 1,
    FFLAG_OF = 2,
    FFLAG_DZ = 3,
    FFLAG_NV = 4
  } fflag_idx_e;

  typedef enum int {
    FPU_SRC_FMA = 0,
    FPU_SRC_CMP = 1,
    FPU_SRC_MV  = 2,
    FPU_SRC_CVT = 3
  } fpu_src_e;

  typedef logic [FFLAGS_W-1:0] fflags_t;

  // A clear discards the history but still records flags delivered in the
  // same cycle, so no exception reported to writeback is ever lost.
  function automatic fflags_t fflags_acc_next(input fflags_t acc,
                                              input fflags_t flags,
                                              input logic    deliver,
                                              input logic    clr);
    fflags_t delivered;
    delivered = deliver ? flags : '0;
    return clr ? delivered : (acc | delivered);
  endfunction

endpackage

// File: rtl/fpu_result_arb_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req : request vector, one bit per requester
//   ptr : highest-priority index this cycle (must be < N)
//   gnt : one-hot grant, all zero when no request
//   idx : binary index of the granted requester (0 when none)
//   any : at least one request is present
module fpu_result_arb_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Walk the requesters starting at ptr, wrapping modulo N; the first hit
  // wins. Indices >= N are never generated, so non-power-of-2 N is safe.
  always_comb begin
    int k;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = 0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/fpu_result_arb.sv
// Result collector for the FPU sub-units. Completed results are arbitrated
// round-robin into a single registered output slot feeding writeback, and
// the exception flags of every delivered result are kept in a sticky
// accumulator for the FCSR.
//   clk, rst_n   : clock, asynchronous active-low reset
//   src_valid_i  : per-source result valid
//   src_ready_o  : per-source accept (transfer on valid & ready)
//   src_result_i : packed results, source k at [k*W +: W]
//   src_fflags_i : packed fflags, source k at [k*5 +: 5]
//   out_valid_o / out_ready_i : output slot handshake
//   out_result_o, out_fflags_o, out_src_o : registered slot contents
//   fflags_clr_i : clear the sticky accumulator
//   fflags_acc_o : sticky OR of fflags of all delivered results
module fpu_result_arb
  import fpu_result_arb_pkg::*;
#(
  parameter int EXPWIDTH  = 8,
  parameter int PRECISION = 24,
  parameter int NUM_SRC   = 4,
  parameter int SRC_W     = $clog2(NUM_SRC)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_SRC-1:0]                  src_valid_i,
  output logic [NUM_SRC-1:0]                  src_ready_o,
  input  logic [NUM_SRC*(EXPWIDTH+PRECISION)-1:0] src_result_i,
  input  logic [NUM_SRC*5-1:0]                src_fflags_i,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic [EXPWIDTH+PRECISION-1:0]       out_result_o,
  output logic [4:0]                          out_fflags_o,
  output logic [SRC_W-1:0]                    out_src_o,
  input  logic                                fflags_clr_i,
  output logic [4:0]                          fflags_acc_o
);

  localparam int W = EXPWIDTH + PRECISION;

  logic [W-1:0]     result_p1;
  fflags_t          fflags_p1;
  logic [SRC_W-1:0] src_p1;
  logic             vld_p1;
  logic [SRC_W-1:0] rr;
  fflags_t          acc;

  logic [NUM_SRC-1:0] gnt;
  logic [SRC_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic               slot_free;
  logic               accept;
  logic               deliver;

  function automatic logic [SRC_W-1:0] next_ptr(input logic [SRC_W-1:0] g);
    if (int'(g) == NUM_SRC - 1) return '0;
    return g + 1'b1;
  endfunction

  // Stage p0: arbitration among sources presenting a result
  fpu_result_arb_rr_arbiter #(
    .N     (NUM_SRC),
    .IDX_W (SRC_W)
  ) u_rr_arbiter (
    .req (src_valid_i),
    .ptr (rr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  // The slot can take a new result when empty or being drained this cycle,
  // which gives back-to-back transfers without a bubble.
  assign slot_free   = !vld_p1 || out_ready_i;
  assign src_ready_o = slot_free ? gnt : '0;
  assign accept      = slot_free && gnt_any;
  assign deliver     = vld_p1 && out_ready_i;

  // Stage p1: registered output slot, round-robin pointer, accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      result_p1 <= '0;
      fflags_p1 <= '0;
      src_p1    <= '0;
      rr        <= '0;
      acc       <= '0;
    end else begin
      if (accept) begin
        vld_p1    <= 1'b1;
        result_p1 <= src_result_i[gnt_idx*W +: W];
        fflags_p1 <= src_fflags_i[gnt_idx*5 +: 5];
        src_p1    <= gnt_idx;
        rr        <= next_ptr(gnt_idx);
      end else if (deliver) begin
        vld_p1 <= 1'b0;
      end
      acc <= fflags_acc_next(acc, fflags_p1, deliver, fflags_clr_i);
    end
  end

  assign out_valid_o  = vld_p1;
  assign out_result_o = result_p1;
  assign out_fflags_o = fflags_p1;
  assign out_src_o    = src_p1;
  assign fflags_acc_o = acc;

endmodule

// File: tb/tb_fpu_result_arb.sv
// Self-checking bench for fpu_result_arb (EXPWIDTH=8, PRECISION=24, 4 sources).
// Directed vector table, hand-written asynchronous reset sequence, then
// randomized traffic checked against a behavioural model of the slot.
module tb_fpu_result_arb;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   src_valid;
  logic [N-1:0]   src_ready;
  logic [N*W-1:0] src_result;
  logic [N*5-1:0] src_fflags;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_result;
  logic [4:0]     out_fflags;
  logic [1:0]     out_src;
  logic           fflags_clr;
  logic [4:0]     fflags_acc;

  fpu_result_arb #(
    .EXPWIDTH  (8),
    .PRECISION (24),
    .NUM_SRC   (N),
    .SRC_W     (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .src_valid_i  (src_valid),
    .src_ready_o  (src_ready),
    .src_result_i (src_result),
    .src_fflags_i (src_fflags),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_result_o (out_result),
    .out_fflags_o (out_fflags),
    .out_src_o    (out_src),
    .fflags_clr_i (fflags_clr),
    .fflags_acc_o (fflags_acc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [19:0] flags;
    logic        ordy;
    logic        clr;
    logic [3:0]  exp_ready;
    logic        exp_vld;
    logic [1:0]  exp_src;
    logic [4:0]  exp_ff;
    logic [4:0]  exp_acc;
  } vec_t;

  vec_t        tbl [20];
  logic [31:0] res_tab [N];

  // Behavioural model state
  int          m_rr;
  bit          m_vld;
  logic [31:0] m_res;
  logic [4:0]  m_ff;
  logic [4:0]  m_acc;
  int          m_src;

  initial begin
    res_tab[0] = 32'h1111_1111;
    res_tab[1] = 32'h2222_2222;
    res_tab[2] = 32'h3F80_0000;
    res_tab[3] = 32'h4444_4444;

    //            valid    flags      rdy   clr   exp_rdy  vld   src   ff         acc
    tbl[0]  = '{4'b0100, 20'h00000, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd2, 5'b00000, 5'b00000};
    tbl[1]  = '{4'b0000, 20'h00000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd2, 5'b00000, 5'b00000};
    tbl[2]  = '{4'b0001, 20'h00001, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 5'b00001, 5'b00000};
    tbl[3]  = '{4'b0010, 20'h00200, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1, 5'b10000, 5'b00001};
    tbl[4]  = '{4'b0000, 20'h00000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd1, 5'b10000, 5'b10001};
    tbl[5]  = '{4'b1000, 20'h20000, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3, 5'b00100, 5'b10001};
    tbl[6]  = '{4'b0000, 20'h00000, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd3, 5'b00100, 5'b00100};
    tbl[7]  = '{4'b0000, 20'h00000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd3, 5'b00100, 5'b00100};
    tbl[8]  = '{4'b0000, 20'h00000, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd3, 5'b00100, 5'b00000};
    tbl[9]  = '{4'b1111, 20'h00000, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 5'b00000, 5'b00000};
    tbl[10] = '{4'b1111, 20'h00000, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1, 5'b00000, 5'b00000};
    tbl[11] = '{4'b1111, 20'h00000, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd2, 5'b00000, 5'b00000};
    tbl[12] = '{4'b1111, 20'h00000, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3, 5'b00000, 5'b00000};
    tbl[13] = '{4'b1111, 20'h00000, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 5'b00000, 5'b00000};
    tbl[14] = '{4'b1010, 20'h00000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 5'b00000, 5'b00000};
    tbl[15] = '{4'b1010, 20'h00000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 5'b00000, 5'b00000};
    tbl[16] = '{4'b1010, 20'h00000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 5'b00000, 5'b00000};
    tbl[17] = '{4'b1010, 20'h00000, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1, 5'b00000, 5'b00000};
    tbl[18] = '{4'b1010, 20'h00000, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3, 5'b00000, 5'b00000};
    tbl[19] = '{4'b0000, 20'h00000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd3, 5'b00000, 5'b00000};

    rst_n      = 1'b0;
    src_valid  = '0;
    src_fflags = '0;
    out_ready  = 1'b0;
    fflags_clr = 1'b0;
    src_result = {res_tab[3], res_tab[2], res_tab[1], res_tab[0]};
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_result", out_result, 32'h0);
    chk("rst_out_fflags", 32'(out_fflags), 32'h0);
    chk("rst_out_src", 32'(out_src), 32'h0);
    chk("rst_acc", 32'(fflags_acc), 32'h0);
    chk("rst_ready", 32'(src_ready), 32'h0);

    // Directed vectors
    for (int r = 0; r < 20; r++) begin
      src_valid  = tbl[r].valid;
      src_fflags = tbl[r].flags;
      out_ready  = tbl[r].ordy;
      fflags_clr = tbl[r].clr;
      #1;
      chk($sformatf("vec%0d_ready", r), 32'(src_ready), 32'(tbl[r].exp_ready));
      tick();
      chk($sformatf("vec%0d_valid", r), 32'(out_valid), 32'(tbl[r].exp_vld));
      chk($sformatf("vec%0d_src", r), 32'(out_src), 32'(tbl[r].exp_src));
      chk($sformatf("vec%0d_result", r), out_result, res_tab[tbl[r].exp_src]);
      chk($sformatf("vec%0d_fflags", r), 32'(out_fflags), 32'(tbl[r].exp_ff));
      chk($sformatf("vec%0d_acc", r), 32'(fflags_acc), 32'(tbl[r].exp_acc));
    end

    // Asynchronous reset with a result in flight, rr=2, acc nonzero
    src_valid  = 4'b0001;
    src_fflags = 20'h00003;
    out_ready  = 1'b1;
    fflags_clr = 1'b0;
    tick();
    chk("ar_setup_src", 32'(out_src), 32'd0);
    src_valid  = 4'b0010;
    src_fflags = 20'h00000;
    tick();
    chk("ar_setup_valid", 32'(out_valid), 32'h1);
    chk("ar_setup_acc", 32'(fflags_acc), 32'h03);
    src_valid = 4'b0000;
    out_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'h0);
    chk("ar_acc", 32'(fflags_acc), 32'h0);
    chk("ar_out_result", out_result, 32'h0);
    chk("ar_out_src", 32'(out_src), 32'h0);
    rst_n = 1'b1;
    #1;
    src_valid = 4'b1001;
    out_ready = 1'b1;
    #1;
    chk("ar_src0_priority", 32'(src_ready), 32'h1);

    // Randomized traffic against the model, starting from reset state
    m_rr  = 0;
    m_vld = 1'b0;
    m_res = '0;
    m_ff  = '0;
    m_acc = '0;
    m_src = 0;
    for (int c = 0; c < 400; c++) begin
      int         g;
      bit         sf;
      bit         dl;
      logic [3:0] er;
      src_valid  = 4'($urandom);
      src_result = {$urandom, $urandom, $urandom, $urandom};
      src_fflags = 20'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      fflags_clr = ($urandom_range(0, 15) == 0);

      g = -1;
      for (int i = 0; i < N; i++)
        if (g < 0 && src_valid[(m_rr + i) % N]) g = (m_rr + i) % N;
      sf = !m_vld || out_ready;
      er = (sf && g >= 0) ? 4'(1 << g) : 4'b0000;
      #1;
      chk("rnd_ready", 32'(src_ready), 32'(er));

      dl = m_vld && out_ready;
      if (fflags_clr) m_acc = dl ? m_ff : 5'b0;
      else if (dl) m_acc = m_acc | m_ff;
      if (sf && g >= 0) begin
        m_vld = 1'b1;
        m_res = src_result[g*W +: W];
        m_ff  = src_fflags[g*5 +: 5];
        m_src = g;
        m_rr  = (g + 1) % N;
      end else if (dl) begin
        m_vld = 1'b0;
      end

      tick();
      chk("rnd_valid", 32'(out_valid), 32'(m_vld));
      chk("rnd_result", out_result, m_res);
      chk("rnd_fflags", 32'(out_fflags), 32'(m_ff));
      chk("rnd_src", 32'(out_src), 32'(m_src));
      chk("rnd_acc", 32'(fflags_acc), 32'(m_acc));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
